alu_dispatcher: RTL

Initiator-side front end for the three-stage pipelined ALU. Accepts operations from a valid/ready requester, stamps each with a valid flag and sequence tag on the ALU's databits sideband, and issues it into the ALU. Collects results on the ALU's fixed-latency return path. Buffers results in a credit-protected FIFO so the backpressure-free ALU can never overrun, and returns them in order on a valid/ready response port.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_dispatch_fifo.sv | 62 ++++++
 rtl/alu_dispatcher.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the three-stage pipelined ALU and its dispatcher:
// opcode encoding, ALU input-to-output latency and the layout of the
// databits sideband (top bit = valid flag, remaining bits = sequence tag).
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MULT = 2'd3
    } alu_op_e;

    localparam int ALU_LATENCY = 3;
    localparam int DATABITS    = 7;
    localparam int DB_VLD_BIT  = DATABITS - 1;
    localparam int DB_TAG_W    = DATABITS - 1;

endpackage

// File: rtl/alu_dispatch_fifo.sv
// alu_dispatch_fifo
// Synchronous result FIFO, DEPTH entries of W bits. Push and pop may happen
// in the same cycle, including when full. The head entry is presented
// combinationally on pop_data; it reads as zero while empty.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   push, push_data write one entry
//   pop             remove the head entry
//   pop_data        head entry
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
module alu_dispatch_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));

endmodule

// File: rtl/alu_dispatcher.sv
// alu_dispatcher
// Initiator-side front end for the pipelined ALU. Requests accepted on the
// valid/ready req_* port are registered into the ALU inputs with a valid flag
// and sequence tag on the databits sideband; idle cycles issue NOP bubbles.
// Results coming back after the ALU's fixed latency are pushed into a result
// FIFO whose space is reserved by credits at issue time, so the ALU (which
// cannot be stalled) never overruns it. Results leave in order on rsp_*.
// Optional feature macro: ALU_DISPATCH_TAGCHECK_EN adds a returned-tag check
// with a sticky err flag; without it err is tied low.
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_op, req_a, req_b           opcode and operands
//   alu_a, alu_b, alu_op,
//   alu_databits                   registered ALU inputs
//   alu_res, alu_out_op,
//   alu_out_databits               ALU return path
//   rsp_valid/rsp_ready            response handshake
//   rsp_res, rsp_op                result and echoed opcode
//   err                            sticky tag-mismatch flag
module alu_dispatcher
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DATABITS    = alu_pkg::DATABITS,
    parameter int DEPTH       = 8,
    parameter int ALU_LATENCY = alu_pkg::ALU_LATENCY
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [WIDTH-1:0]    req_a,
    input  logic [WIDTH-1:0]    req_b,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [1:0]          alu_op,
    output logic [DATABITS-1:0] alu_databits,
    input  logic [WIDTH-1:0]    alu_res,
    input  logic [1:0]          alu_out_op,
    input  logic [DATABITS-1:0] alu_out_databits,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_res,
    output logic [1:0]          rsp_op,
    output logic                err
);

    localparam int TAG_W = DATABITS - 1;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int WCW   = $clog2(ALU_LATENCY + 2);

    logic [CW-1:0]    inflight;
    logic [CW-1:0]    occ;
    logic [CW:0]      credit_sum;
    logic [TAG_W-1:0] seq;
    logic [WCW-1:0]   warm_cnt;
    logic             warm_done;
    logic             issue;
    logic             ret;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH+1:0] fifo_dout;

    // Returns are ignored until the ALU pipeline has been refilled with
    // bubbles after reset, covering anything issued before reset.
    assign warm_done  = (warm_cnt == WCW'(ALU_LATENCY + 1));
    assign credit_sum = {1'b0, inflight} + {1'b0, occ};
    assign req_ready  = warm_done && (credit_sum < (CW+1)'(DEPTH));
    assign issue      = req_valid && req_ready;
    assign ret        = warm_done && alu_out_databits[DATABITS-1];
    assign rsp_valid  = !fifo_empty;
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_res    = fifo_dout[WIDTH+1:2];
    assign rsp_op     = fifo_dout[1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= OP_NOP;
            alu_databits <= '0;
            seq          <= '0;
            inflight     <= '0;
            warm_cnt     <= '0;
        end else begin
            if (!warm_done) warm_cnt <= warm_cnt + 1'b1;

            if (issue) begin
                alu_a        <= req_a;
                alu_b        <= req_b;
                alu_op       <= req_op;
                alu_databits <= {1'b1, seq};
                seq          <= seq + 1'b1;
            end else begin
                alu_a        <= '0;
                alu_b        <= '0;
                alu_op       <= OP_NOP;
                alu_databits <= '0;
            end

            case ({issue, ret})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    alu_dispatch_fifo #(
        .W     (WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ret),
        .push_data ({alu_res, alu_out_op}),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occ)
    );

`ifdef ALU_DISPATCH_TAGCHECK_EN
    logic [TAG_W-1:0] exp_tag;
    logic             err_q;

    // Mismatching entries are still delivered; only the flag records it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exp_tag <= '0;
            err_q   <= 1'b0;
        end else if (ret) begin
            exp_tag <= exp_tag + 1'b1;
            if (alu_out_databits[TAG_W-1:0] != exp_tag) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_tag;
    assign unused_tag = ^alu_out_databits[TAG_W-1:0];
    assign err        = 1'b0;
`endif

    a_no_return_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(ret && !issue && inflight == '0));
    a_full_has_credit: assert property (@(posedge clk) disable iff (!reset)
        !(fifo_full && ret && !pop));

endmodule
